shifter_cmd_loader: RTL

//   Upstream front end for the board barrel shifter. Synchronises and debounces the five

---
 rtl/shifter_cmd_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/shifter_cmd_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : shifter_cmd_loader
//  Description : Button/switch front end for the board barrel shifter.
//                Synchronises and debounces five buttons, assembles a 32-bit
//                operand nibble by nibble, latches a 5-bit shift amount and
//                issues one shift command per shift-button press under a
//                valid/ready handshake.
//  Config      : DEBOUNCE_BYPASS_EN - when defined, the debounce counters are
//                removed and the debounced level equals the synchronised level.
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter_cmd_loader #(
  parameter int DB_CYCLES = 500000,  // stable cycles required to accept a level change
  parameter int DB_W      = 20       // debounce counter width, 2**DB_W > DB_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  number,
  input  logic [4:0]  data_in,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic        btn_sra,
  input  logic        btn_srl,
  input  logic        btn_sll,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] operand,
  output logic [4:0]  shamt,
  output logic [1:0]  op
);

  // Button lane indices inside the packed button vectors
  localparam int c_NBTN    = 5;
  localparam int c_BTN_A   = 0;
  localparam int c_BTN_B   = 1;
  localparam int c_BTN_SRA = 2;
  localparam int c_BTN_SRL = 3;
  localparam int c_BTN_SLL = 4;

  // Operation encodings presented on op
  localparam logic [1:0] c_OP_NONE = 2'b00;
  localparam logic [1:0] c_OP_SRL  = 2'b01;
  localparam logic [1:0] c_OP_SLL  = 2'b10;
  localparam logic [1:0] c_OP_SRA  = 2'b11;

  // Command FSM states
  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_PEND = 1'b1;

  logic [c_NBTN-1:0] w_btn_raw;
  logic [c_NBTN-1:0] sync1_q;
  logic [c_NBTN-1:0] sync2_q;
  logic [c_NBTN-1:0] w_deb;
  logic [c_NBTN-1:0] deb_prev_q;
  logic [c_NBTN-1:0] w_press;

  logic [0:0]  state_q,   state_d;
  logic [31:0] operand_q, operand_d;
  logic [4:0]  shamt_q,   shamt_d;
  logic [1:0]  op_q,      op_d;
  logic        valid_q,   valid_d;

  assign w_btn_raw = {btn_sll, btn_srl, btn_sra, btn_b, btn_a};

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= w_btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN
  // Buttons are already clean: the synchronised level is the debounced level
  assign w_deb = sync2_q;
`else
  genvar gi;
  generate
    for (gi = 0; gi < c_NBTN; gi++) begin : g_db
      logic [DB_W-1:0] cnt_q;
      logic            lvl_q;

      // Count consecutive cycles of disagreement; flip the level once it has
      // persisted for DB_CYCLES cycles, any agreement restarts the count
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else if (sync2_q[gi] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
          cnt_q <= '0;
          lvl_q <= sync2_q[gi];
        end else begin
          cnt_q <= cnt_q + DB_W'(1);
        end
      end

      assign w_deb[gi] = lvl_q;
    end
  endgenerate
`endif

  // Remember the previous debounced level to find rising edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev_q <= '0;
    end else begin
      deb_prev_q <= w_deb;
    end
  end

  // One-cycle press pulse on each debounced rising edge; releases are ignored
  assign w_press = w_deb & ~deb_prev_q;

  // Command FSM next-state: loads and shift requests in IDLE, hold in PEND
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    shamt_d   = shamt_q;
    op_d      = op_q;
    valid_d   = valid_q;
    case (state_q)
      c_IDLE: begin
        // Loads are applied in the same update as a shift request, so the
        // issued command already carries the freshly loaded values.
        if (w_press[c_BTN_A]) begin
          operand_d[{number, 2'b00} +: 4] = data_in[3:0];
        end
        if (w_press[c_BTN_B]) begin
          shamt_d = data_in;
        end
        if (w_press[c_BTN_SRA]) begin
          op_d    = c_OP_SRA;
          valid_d = 1'b1;
          state_d = c_PEND;
        end else if (w_press[c_BTN_SRL]) begin
          op_d    = c_OP_SRL;
          valid_d = 1'b1;
          state_d = c_PEND;
        end else if (w_press[c_BTN_SLL]) begin
          op_d    = c_OP_SLL;
          valid_d = 1'b1;
          state_d = c_PEND;
        end
      end
      c_PEND: begin
        // Everything is frozen until the shifter takes the command; presses
        // arriving now are dropped rather than queued.
        if (cmd_ready) begin
          valid_d = 1'b0;
          op_d    = c_OP_NONE;
          state_d = c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Command FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_IDLE;
      operand_q <= '0;
      shamt_q   <= '0;
      op_q      <= c_OP_NONE;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      shamt_q   <= shamt_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
    end
  end

  assign cmd_valid = valid_q;
  assign operand   = operand_q;
  assign shamt     = shamt_q;
  assign op        = op_q;

endmodule
`default_nettype wire
